// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Conflict monitor between the intersection light controller and the lamp board.
// It registers the controller's lamp vector every cycle and checks each direction for:
//   - a valid lamp encoding
//   - cross-direction conflicts
//   - legal phase order
//   - minimum green and yellow hold times
//   - a maximum time the whole vector may stay unchanged
// The first fault found is latched. While healthy the board sees the controller's
// lamps delayed by one cycle. Once faulted, both directions flash red.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   lights       controller lamp vector {G1,Y1,R1,G2,Y2,R2}, 1 = lamp on
//   clr          synchronous fault clear pulse, honoured only while faulted
//   safe_lights  lamp vector driven to the board, same bit order
//   fault        sticky fault flag
//   fault_code   code of the latched fault, 0 when healthy
//                (1 invalid, 2 conflict, 3 sequence, 4 short yellow, 5 short green, 6 stuck)
//   active       high while the checks are armed (RUN)
module traffic_light_monitor #(
  parameter logic [31:0] MIN_GREEN_CYC  = 32'd200000000,
  parameter logic [31:0] MIN_YELLOW_CYC = 32'd100000000,
  parameter logic [31:0] MAX_PHASE_CYC  = 32'd1000000000,
  parameter logic [31:0] FLASH_CYC      = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] lights,
  input  logic       clr,
  output logic [5:0] safe_lights,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       active
);

  // Per-direction lamp encodings {G,Y,R}
  localparam logic [2:0] LampG = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampR = 3'b001;

  localparam logic [5:0] BothRed = 6'b001001;

  localparam logic [2:0] CodeNone     = 3'd0;
  localparam logic [2:0] CodeInvalid  = 3'd1;
  localparam logic [2:0] CodeConflict = 3'd2;
  localparam logic [2:0] CodeSequence = 3'd3;
  localparam logic [2:0] CodeShortY   = 3'd4;
  localparam logic [2:0] CodeShortG   = 3'd5;
  localparam logic [2:0] CodeStuck    = 3'd6;

  typedef enum logic [1:0] {StArm, StRun, StFault} state_e;

  state_e state_q, state_d;

  logic [5:0]       lights_q, prev_q;
  logic [1:0][2:0]  cur_dir, prev_dir;     // index 1 = dir1 [5:3], index 0 = dir2 [2:0]
  logic [1:0][31:0] dur_q, dur_d;
  logic [1:0]       first_q, first_d;
  logic [31:0]      stuck_q, stuck_d;
  logic [31:0]      flash_cnt_q, flash_cnt_d;
  logic             flash_q, flash_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;

  logic [1:0]  dir_chg;
  logic        vec_chg;
  logic [31:0] stuck_run;
  logic        chk_invalid, chk_conflict, chk_seq, chk_short_y, chk_short_g, chk_stuck;
  logic [2:0]  det_code;
  logic        det;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LampG) || (v == LampY) || (v == LampR);
  endfunction

  function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
    return ((from == LampG) && (to == LampY)) ||
           ((from == LampY) && (to == LampR)) ||
           ((from == LampR) && (to == LampG));
  endfunction

  assign cur_dir  = lights_q;
  assign prev_dir = prev_q;
  assign dir_chg  = {cur_dir[1] != prev_dir[1], cur_dir[0] != prev_dir[0]};
  assign vec_chg  = |dir_chg;

  // Cycles the full vector has been unchanged, counting the current cycle
  assign stuck_run = vec_chg ? 32'd1 : sat_inc(stuck_q);

  //--------------------------------------------------------------------------
  // Input pipeline: always runs, independent of the FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lights_q <= BothRed;
      prev_q   <= BothRed;
    end else begin
      lights_q <= lights;
      prev_q   <= lights_q;
    end
  end

  //--------------------------------------------------------------------------
  // Checks on the current vs previous registered vector
  //--------------------------------------------------------------------------
  always_comb begin
    chk_invalid = 1'b0;
    chk_seq     = 1'b0;
    chk_short_y = 1'b0;
    chk_short_g = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!is_onehot3(cur_dir[d])) chk_invalid = 1'b1;
      if (dir_chg[d]) begin
        if (!legal_step(prev_dir[d], cur_dir[d])) chk_seq = 1'b1;
        if ((prev_dir[d] == LampY) && (cur_dir[d] == LampR) &&
            (dur_q[d] < MIN_YELLOW_CYC) && !first_q[d]) begin
          chk_short_y = 1'b1;
        end
        if ((prev_dir[d] == LampG) && (cur_dir[d] == LampY) &&
            (dur_q[d] < MIN_GREEN_CYC) && !first_q[d]) begin
          chk_short_g = 1'b1;
        end
      end
    end
  end

  assign chk_conflict = (cur_dir[1][2] | cur_dir[1][1]) & (cur_dir[0][2] | cur_dir[0][1]);
  assign chk_stuck    = (stuck_run == MAX_PHASE_CYC);

  // Lowest code wins; ARM only has a valid current vector, so only static checks apply
  always_comb begin
    det_code = CodeNone;
    if (state_q == StArm) begin
      if (chk_invalid)       det_code = CodeInvalid;
      else if (chk_conflict) det_code = CodeConflict;
    end else if (state_q == StRun) begin
      if (chk_invalid)       det_code = CodeInvalid;
      else if (chk_conflict) det_code = CodeConflict;
      else if (chk_seq)      det_code = CodeSequence;
      else if (chk_short_y)  det_code = CodeShortY;
      else if (chk_short_g)  det_code = CodeShortG;
      else if (chk_stuck)    det_code = CodeStuck;
    end
  end

  assign det = (det_code != CodeNone);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StArm;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArm:   state_d = det ? StFault : StRun;
      StRun:   if (det) state_d = StFault;
      StFault: if (clr) state_d = StArm;
      default: state_d = StArm;
    endcase
  end

  //--------------------------------------------------------------------------
  // Counters, exemption flags, flash and fault latch: next state
  //--------------------------------------------------------------------------
  always_comb begin
    dur_d       = dur_q;
    first_d     = first_q;
    stuck_d     = stuck_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    fault_d     = fault_q;
    code_d      = code_q;

    unique case (state_q)
      StArm: begin
        first_d = 2'b11;
      end
      StRun: begin
        for (int d = 0; d < 2; d++) begin
          dur_d[d] = dir_chg[d] ? 32'd1 : sat_inc(dur_q[d]);
          // dur_q is zero only in the first RUN cycle, where prev_q still holds the stale
          // ARM-time vector; that change does not end a timed phase, so the phase in
          // flight at arming stays exempt until its own exit.
          if (dir_chg[d] && (dur_q[d] != 32'd0)) first_d[d] = 1'b0;
        end
        stuck_d = stuck_run;
      end
      StFault: begin
        if (clr) begin
          dur_d       = '0;
          stuck_d     = '0;
          first_d     = 2'b11;
          flash_cnt_d = '0;
          flash_d     = 1'b0;
          fault_d     = 1'b0;
          code_d      = CodeNone;
        end else if (flash_cnt_q == FLASH_CYC - 32'd1) begin
          flash_cnt_d = '0;
          flash_d     = ~flash_q;
        end else begin
          flash_cnt_d = flash_cnt_q + 32'd1;
        end
      end
      default: ;
    endcase

    // Fault entry from ARM or RUN: latch the code and start the flash with red lit
    if ((state_q != StFault) && det) begin
      fault_d     = 1'b1;
      code_d      = det_code;
      flash_d     = 1'b1;
      flash_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q       <= '0;
      first_q     <= 2'b11;
      stuck_q     <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= CodeNone;
    end else begin
      dur_q       <= dur_d;
      first_q     <= first_d;
      stuck_q     <= stuck_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    active      = (state_q == StRun);
    fault       = fault_q;
    fault_code  = code_q;
    safe_lights = lights_q;
    if (state_q == StFault) safe_lights = {2'b00, flash_q, 2'b00, flash_q};
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Conflict monitor for the two-way intersection light controller. It samples the controller's 6-bit lamp vector every clock, checks per-direction encoding, cross-direction conflicts, phase ordering, minimum green/yellow and maximum phase durations, and latches the first fault. It drives a fail-safe lamp vector to the board: a pass-through of the controller when healthy, and flashing red on both directions once faulted.

## Interface
- MIN_GREEN_CYC, 32'd200000000, minimum cycles a green must be held (2 s at 100 MHz)
- MIN_YELLOW_CYC, 32'd100000000, minimum cycles a yellow must be held
- MAX_PHASE_CYC, 32'd1000000000, maximum cycles the full 6-bit vector may stay unchanged
- FLASH_CYC, 32'd50000000, half-period of fail-safe red flash
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- lights  in  6  controller lamp vector {G1,Y1,R1,G2,Y2,R2}, 1 = lamp on
- clr  in  1  synchronous fault clear, single-cycle pulse
- safe_lights  out  6  lamp vector to board, same bit order
- fault  out  1  sticky fault flag
- fault_code  out  3  code of latched fault, 0 when no fault
- active  out  1  high in RUN (checks armed)

## Operation
- lights_q <= lights every cycle; prev_q <= lights_q. All checks use lights_q (cur) vs prev_q.
- States: ARM -> RUN -> FAULT. Reset enters ARM. ARM lasts exactly one cycle (prev_q not yet valid), then RUN. Any detected fault in RUN -> FAULT. In FAULT, clr -> ARM. clr outside FAULT: no effect.
- Per direction d (bits [5:3] = dir1, [2:0] = dir2): dur_d is the number of consecutive cycles cur_d has held its value; reset to 1 when cur_d != prev_d, otherwise increment, saturating at 32'hFFFFFFFF. first_d set in ARM, cleared on first change of dir d.
- stuck_cnt: cycles the full cur vector has been unchanged; reset to 1 on any change, saturating.
- Checks in RUN, codes in priority order (lowest wins when several fire the same cycle):
  - 1 INVALID: cur_d not exactly one-hot for either direction.
  - 2 CONFLICT: G or Y lit on both directions.
  - 3 SEQUENCE: cur_d != prev_d and the transition is not G->Y, Y->R, or R->G.
  - 4 SHORT_YELLOW: Y->R transition with dur_d < MIN_YELLOW_CYC and first_d clear.
  - 5 SHORT_GREEN: G->Y transition with dur_d < MIN_GREEN_CYC and first_d clear.
  - 6 STUCK: stuck_cnt == MAX_PHASE_CYC.
- INVALID/CONFLICT are also checked in ARM, against cur only. SEQUENCE/duration/STUCK are not checked in ARM.
- Fault latched: fault <= 1, fault_code <= code. Held until clr or rst_n; later faults do not overwrite the code.
- safe_lights: in ARM/RUN = lights_q. In FAULT = {2'b00,f,2'b00,f}. f starts at 1 on FAULT entry and toggles every FLASH_CYC cycles via a 32-bit flash counter.
- Leaving FAULT via clr: counters cleared, first_d re-set, ARM.

## Timing
- Reset values: safe_lights 6'b001001 (both red), fault 0, fault_code 0, active 0, lights_q/prev_q 6'b001001, all counters 0, state ARM.
- Pin-to-fault latency: 2 cycles (lights at edge t -> lights_q at t+1 -> fault/fault_code registered at t+2).
- safe_lights pass-through latency: 1 cycle. The first cycle of FAULT already drives flash red.
- active rises the cycle after ARM, falls in the same cycle fault rises.
- clr coincident with a new detection while in FAULT: clr wins, ARM entered. Detection in the ARM cycle after clr latches normally.
- rst_n assertion mid-operation: all state returns to reset values immediately (asynchronous). Deassertion is sampled on the next clk edge.
- A boundary-exact hold is legal: dur_d == MIN_* passes; stuck_cnt == MAX_PHASE_CYC faults.

## Test plan
Sim parameters: MIN_GREEN_CYC=8, MIN_YELLOW_CYC=4, MAX_PHASE_CYC=32, FLASH_CYC=2.
- Legal cycle: 100001 for 10 cycles, 010001 for 4, 001001 for 2, 001100 for 10, 001010 for 4, repeat x3 -> fault stays 0, and safe_lights equals lights delayed by 1.
- Conflict: apply 100100 from RUN -> fault=1, fault_code=2 two cycles later, safe_lights 001001/000000 alternating every 2 cycles.
- Short yellow: after a legal green, hold 010001 for 3 cycles then 001001 -> fault_code=4. Repeat with a 4-cycle hold -> no fault.
- Sequence plus invalid in the same cycle: from 100001 apply 001000 -> fault_code=1 (priority over 3).
- Stuck: hold 100001 for 32 cycles -> fault_code=6 exactly on the 32nd cycle + 2. Pulse clr -> active returns after one ARM cycle, and fault=0.
- Reset mid-fault: assert rst_n=0 while flashing -> safe_lights=001001, fault=0 immediately. First phase after reset held 2 cycles G -> no SHORT_GREEN (first_d exemption).
